// File: rtl/ps2_pkg.sv
// ps2_pkg: definitions shared by the PS/2 host transmitter and receiver.
//   - ps2_state_e : host-transmit FSM state encoding
//   - FRAME_BITS  : bits the host drives after the start bit (8 data, parity, stop)
//   - ACK_EDGE    : device falling edge on which the ack bit is sampled
//   - CMD_*       : common host-to-device command bytes
//   - ps2_frame() : builds the outgoing frame {stop, odd parity, data}
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_SHIFT     = 3'd3,
    S_ACK       = 3'd4,
    S_WAIT_IDLE = 3'd5
  } ps2_state_e;

  localparam int FRAME_BITS = 10;
  localparam int ACK_EDGE   = 11;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;

  // LSB is sent first; the parity bit makes the count of ones in data+parity odd.
  function automatic logic [FRAME_BITS-1:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchronizer for the raw PS/2 clock and data pins plus
// a one-cycle falling-edge pulse on the clock line.
//   i_clk, i_rst           : system clock, async active-high reset
//   i_ps2_clk, i_ps2_data  : raw asynchronous pin levels
//   o_clk_lvl, o_data_lvl  : synchronized levels
//   o_clk_fall             : one-cycle pulse on a synchronized clock falling edge
module ps2_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_lvl,
  output logic o_data_lvl,
  output logic o_clk_fall
);

  logic [1:0] r_clk_sync;
  logic [1:0] r_data_sync;

  // Reset to the bus idle level (high) so leaving reset never fakes an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
    end
  end

  assign o_clk_fall = r_clk_sync[1] & ~r_clk_sync[0];
  assign o_clk_lvl  = r_clk_sync[1];
  assign o_data_lvl = r_data_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte using the
// inhibit / request-to-send / shift / ack sequence, driving both lines open-drain.
//   i_clk, i_rst      : system clock, async active-high reset
//   i_ps2_clk/_data   : raw pin levels (shared with the receiver)
//   i_wrn, i_din      : active-low write strobe and byte, accepted only when idle
//   o_ps2_clk_oe/_data_oe : 1 = pull the line low
//   o_tx_busy         : transfer in progress (gates the receiver)
//   o_tx_done         : one-cycle pulse when the device acknowledged the frame
//   o_tx_err          : sticky NACK/timeout flag, cleared by the next accepted write
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  input  logic       i_wrn,
  input  logic [7:0] i_din,
  output logic       o_ps2_clk_oe,
  output logic       o_ps2_data_oe,
  output logic       o_tx_busy,
  output logic       o_tx_done,
  output logic       o_tx_err
);

  localparam logic [19:0] INH_LAST = 20'(INHIBIT_CYC - 1);
  localparam logic [19:0] TO_LAST  = 20'(TIMEOUT_CYC - 1);

  ps2_state_e            r_state, w_state_nxt;
  logic [19:0]           r_timer;
  logic [3:0]            r_bitcnt;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_clk_oe, r_data_oe, r_done, r_err;
  logic                  w_clk_oe_d, w_data_oe_d, w_done_d, w_err_d;
  logic                  w_clk_lvl, w_data_lvl, w_fall;
  logic                  w_inh_end, w_timeout, w_lines_idle;

  ps2_sync_edge u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ps2_clk  (i_ps2_clk),
    .i_ps2_data (i_ps2_data),
    .o_clk_lvl  (w_clk_lvl),
    .o_data_lvl (w_data_lvl),
    .o_clk_fall (w_fall)
  );

  assign w_inh_end    = (r_timer == INH_LAST);
  // A device edge restarts the timer, so it wins over an expiry in the same cycle.
  assign w_timeout    = (r_timer == TO_LAST) && !w_fall;
  assign w_lines_idle = w_clk_lvl && w_data_lvl;

  // State and registered outputs (oe registered so the pins never glitch).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_clk_oe  <= 1'b0;
      r_data_oe <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_oe  <= w_clk_oe_d;
      r_data_oe <= w_data_oe_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (!i_wrn) w_state_nxt = S_INHIBIT;
      S_INHIBIT:   if (w_inh_end) w_state_nxt = S_REQ;
      S_REQ:       if (w_fall) w_state_nxt = S_SHIFT;
                   else if (w_timeout) w_state_nxt = S_IDLE;
      S_SHIFT:     if (w_fall && r_bitcnt == 4'(FRAME_BITS - 1)) w_state_nxt = S_ACK;
                   else if (w_timeout) w_state_nxt = S_IDLE;
      S_ACK:       if (w_fall) w_state_nxt = w_data_lvl ? S_IDLE : S_WAIT_IDLE;
                   else if (w_timeout) w_state_nxt = S_IDLE;
      S_WAIT_IDLE: if (w_lines_idle || w_timeout) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered pins and status flags.
  always_comb begin
    w_clk_oe_d  = (w_state_nxt == S_INHIBIT);
    w_data_oe_d = 1'b0;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    case (r_state)
      S_IDLE:    if (!i_wrn) w_err_d = 1'b0;
      // Start bit goes low together with the clock release.
      S_INHIBIT: w_data_oe_d = w_inh_end;
      S_REQ, S_SHIFT: begin
        if (w_fall)         w_data_oe_d = ~r_frame[0];
        else if (w_timeout) w_err_d     = 1'b1;
        else                w_data_oe_d = r_data_oe;
      end
      S_ACK: begin
        if (w_fall)         w_err_d = r_err | w_data_lvl;
        else if (w_timeout) w_err_d = 1'b1;
      end
      S_WAIT_IDLE: begin
        if (w_lines_idle)   w_done_d = 1'b1;
        else if (w_timeout) w_err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  // Timer, bit counter and frame shifter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_frame  <= '0;
    end else begin
      // Our own clock pull-down shows up as a fall during INHIBIT; it must not
      // stretch the inhibit period.
      if (r_state != w_state_nxt || (w_fall && r_state != S_INHIBIT))
        r_timer <= '0;
      else if (r_state != S_IDLE)
        r_timer <= r_timer + 20'd1;

      if (r_state == S_IDLE || r_state == S_INHIBIT)
        r_bitcnt <= '0;
      else if (w_fall && r_bitcnt != 4'(ACK_EDGE))
        r_bitcnt <= r_bitcnt + 4'd1;

      if (r_state == S_IDLE && !i_wrn)
        r_frame <= ps2_frame(i_din);
      else if (w_fall && (r_state == S_REQ || r_state == S_SHIFT))
        r_frame <= {1'b1, r_frame[FRAME_BITS-1:1]};
    end
  end

  assign o_ps2_clk_oe  = r_clk_oe;
  assign o_ps2_data_oe = r_data_oe;
  assign o_tx_busy     = (r_state != S_IDLE);
  assign o_tx_done     = r_done;
  assign o_tx_err      = r_err;

endmodule
